// File: rtl/mipi_csi_rx_raw_depacker_16b2lane_pkg.sv
// Shared CSI-2 RX constants and helpers for the RAW depacker.
// - DataID codes and the 3-bit packet type codes seen on packet_type_i
// - group sizes (bytes per 4 pixels) for RAW10/12/14
// - unpack_px: extracts one 14-bit pixel from a group of wire-order bytes
package csi_rx_pkg;

  localparam int MIPI_GEAR      = 16;
  localparam int LANES          = 2;
  localparam int IN_BYTES       = MIPI_GEAR * LANES / 8;  // 4 bytes/clk
  localparam int PIXELS_PER_CLK = 4;
  localparam int BUF_BYTES      = 10;                     // worst case: 6 held + 4 appended
  localparam int GRP_MAX        = 7;

  localparam logic [7:0] DT_RAW10 = 8'h2B;
  localparam logic [7:0] DT_RAW12 = 8'h2C;
  localparam logic [7:0] DT_RAW14 = 8'h2D;

  localparam logic [2:0] PT_RAW10 = 3'h3;
  localparam logic [2:0] PT_RAW12 = 3'h4;
  localparam logic [2:0] PT_RAW14 = 3'h5;

  localparam logic [3:0] G_RAW10 = 4'd5;
  localparam logic [3:0] G_RAW12 = 4'd6;
  localparam logic [3:0] G_RAW14 = 4'd7;

  // Group byte b0 sits in element 0.
  typedef logic [GRP_MAX-1:0][7:0] group_t;

  // 0 marks an unsupported type: the burst is dropped.
  function automatic logic [3:0] group_size(input logic [2:0] t);
    case (t)
      PT_RAW10: return G_RAW10;
      PT_RAW12: return G_RAW12;
      PT_RAW14: return G_RAW14;
      default:  return 4'd0;
    endcase
  endfunction

  function automatic logic [13:0] unpack_px(input logic [2:0] t, input group_t g,
                                            input logic [1:0] k);
    logic [13:0] p;
    p = '0;
    case (t)
      // 8 MSBs per pixel, then one byte carrying 2 LSBs for each pixel
      PT_RAW10: p = {4'd0, g[k], 2'(g[4] >> {k, 1'b0})};
      // two pixels share one LSB byte, low nibble first
      PT_RAW12: begin
        case (k)
          2'd0:    p = {2'd0, g[0], g[2][3:0]};
          2'd1:    p = {2'd0, g[1], g[2][7:4]};
          2'd2:    p = {2'd0, g[3], g[5][3:0]};
          default: p = {2'd0, g[4], g[5][7:4]};
        endcase
      end
      // 6-bit LSB fields are packed little-endian across the trailing 3 bytes
      PT_RAW14: begin
        case (k)
          2'd0:    p = {g[0], g[4][5:0]};
          2'd1:    p = {g[1], g[5][3:0], g[4][7:6]};
          2'd2:    p = {g[2], g[6][1:0], g[5][7:4]};
          default: p = {g[3], g[6][7:2]};
        endcase
      end
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mipi_csi_rx_raw_depacker_16b2lane_if.sv
// Payload-in / pixels-out bus of the RAW depacker.
// slave  : the depacker (consumes payload, drives pixels)
// master : the upstream decoder / downstream sink side
interface mipi_csi_rx_raw_depacker_16b2lane_if #(
  parameter int PIXEL_BITS = 16
);
  import csi_rx_pkg::*;

  logic                                         data_valid_i;
  logic [8*IN_BYTES-1:0]                        data_i;
  logic [2:0]                                   packet_type_i;
  logic                                         output_valid_o;
  logic [PIXELS_PER_CLK-1:0][PIXEL_BITS-1:0]    pixel_o;
  logic                                         line_end_o;
  logic                                         residue_err_o;

  modport slave (
    input  data_valid_i, data_i, packet_type_i,
    output output_valid_o, pixel_o, line_end_o, residue_err_o
  );

  modport master (
    output data_valid_i, data_i, packet_type_i,
    input  output_valid_o, pixel_o, line_end_o, residue_err_o
  );

endinterface

// File: rtl/mipi_csi_rx_byte_accumulator.sv
// Append-4 / pop-G byte buffer.
// clk_i, reset_i : clock, async active-high reset
// push_i, data_i : append 4 bytes (byte0 = data_i[7:0]) behind held bytes
// clear_i        : drop everything held
// grp_size_i     : G (5..7); 0 disables popping
// grp_vld_o      : a full group is available this clk (combinational)
// grp_o          : lowest G bytes of the buffer+append (valid with grp_vld_o)
// count_o        : bytes currently held
module mipi_csi_rx_byte_accumulator
  import csi_rx_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic                  clear_i,
  input  logic [8*IN_BYTES-1:0] data_i,
  input  logic [3:0]            grp_size_i,
  output logic                  grp_vld_o,
  output group_t                grp_o,
  output logic [3:0]            count_o
);

  localparam int BW = 8 * BUF_BYTES;

  logic [BW-1:0] buf_q, buf_d;
  logic [BW-1:0] keep, merged;
  logic [3:0]    cnt_q, cnt_d;
  logic [4:0]    fill;

  always_comb begin
    // Held bytes are masked by count so the append never ORs into stale data.
    keep   = buf_q & ~({BW{1'b1}} << {cnt_q, 3'b000});
    merged = keep | (push_i ? (BW'(data_i) << {cnt_q, 3'b000}) : '0);
    fill   = 5'(cnt_q) + (push_i ? 5'd4 : 5'd0);

    grp_vld_o = push_i && (grp_size_i != 4'd0) && (fill >= 5'(grp_size_i));
    grp_o     = merged[8*GRP_MAX-1:0];

    buf_d = merged;
    cnt_d = 4'(fill);
    if (clear_i) begin
      buf_d = '0;
      cnt_d = 4'd0;
    end else if (grp_vld_o) begin
      buf_d = merged >> {grp_size_i, 3'b000};
      cnt_d = 4'(fill - 5'(grp_size_i));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buf_q <= '0;
      cnt_q <= 4'd0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/mipi_csi_rx_raw_depacker_16b2lane.sv
// CSI-2 RAW10/12/14 depacker: 4 payload bytes/clk in, 4 right-justified pixels per beat out.
// clk_i   : MIPI byte clock
// reset_i : async active-high reset
// bus     : slave side of the depacker bus
//   data_valid_i/data_i/packet_type_i  payload in, type latched at burst start
//   output_valid_o/pixel_o             4 pixels, P0 in the lowest slot, held when idle
//   line_end_o                         1-clk pulse after a supported burst ends
//   residue_err_o                      with line_end_o when leftover bytes were dropped
module mipi_csi_rx_raw_depacker_16b2lane
  import csi_rx_pkg::*;
#(
  parameter int PIXEL_BITS = 16  // >= 14
)(
  input  logic clk_i,
  input  logic reset_i,
  mipi_csi_rx_raw_depacker_16b2lane_if.slave bus
);

  logic       vld_q;
  logic [2:0] type_q;
  logic       burst_start, burst_end;
  logic [2:0] type_cur;
  logic [3:0] grp_size;
  logic       push;
  logic       grp_vld;
  group_t     grp;
  logic [3:0] count;

  logic [PIXELS_PER_CLK-1:0][PIXEL_BITS-1:0] px_d, pix_q;
  logic out_vld_q, line_end_q, residue_q;

  assign burst_start = bus.data_valid_i && !vld_q;
  assign burst_end   = !bus.data_valid_i && vld_q;

  // The first beat of a burst must already decode with the new type.
  assign type_cur = burst_start ? bus.packet_type_i : type_q;
  assign grp_size = group_size(type_cur);
  assign push     = bus.data_valid_i && (grp_size != 4'd0);

  mipi_csi_rx_byte_accumulator u_acc (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .push_i     (push),
    .clear_i    (burst_end),
    .data_i     (bus.data_i),
    .grp_size_i (grp_size),
    .grp_vld_o  (grp_vld),
    .grp_o      (grp),
    .count_o    (count)
  );

  for (genvar k = 0; k < PIXELS_PER_CLK; k++) begin : g_px
    assign px_d[k] = PIXEL_BITS'(unpack_px(type_cur, grp, 2'(k)));
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vld_q      <= 1'b0;
      type_q     <= 3'd0;
      out_vld_q  <= 1'b0;
      pix_q      <= '0;
      line_end_q <= 1'b0;
      residue_q  <= 1'b0;
    end else begin
      vld_q     <= bus.data_valid_i;
      if (burst_start) type_q <= bus.packet_type_i;
      out_vld_q <= grp_vld;
      if (grp_vld) pix_q <= px_d;
      // type_cur == type_q on the end clk; unsupported bursts stay silent
      line_end_q <= burst_end && (grp_size != 4'd0);
      residue_q  <= burst_end && (grp_size != 4'd0) && (count != 4'd0);
    end
  end

  assign bus.output_valid_o = out_vld_q;
  assign bus.pixel_o        = pix_q;
  assign bus.line_end_o     = line_end_q;
  assign bus.residue_err_o  = residue_q;

endmodule

// File: tb/tb_mipi_csi_rx_raw_depacker_16b2lane.sv
module tb_mipi_csi_rx_raw_depacker_16b2lane;
  import csi_rx_pkg::*;

  localparam int PB = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mipi_csi_rx_raw_depacker_16b2lane_if #(.PIXEL_BITS(PB)) bus();

  mipi_csi_rx_raw_depacker_16b2lane #(.PIXEL_BITS(PB)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model: a byte FIFO per burst, pixels from the format formulas
  byte unsigned mq[$];
  logic         m_prev = 1'b0;
  int           m_type = 0;
  logic         exp_vld = 1'b0, exp_le = 1'b0, exp_res = 1'b0;
  logic [3:0][PB-1:0] exp_pix = '0;

  function automatic int gsize(input int t);
    case (t)
      3: return 5;
      4: return 6;
      5: return 7;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    mq.delete();
    m_prev  = 1'b0;
    m_type  = 0;
    exp_vld = 1'b0;
    exp_le  = 1'b0;
    exp_res = 1'b0;
    exp_pix = '0;
  endtask

  // Drive one clock of input, advance the model, return at posedge+1.
  task automatic cyc(input logic v, input logic [31:0] d, input logic [2:0] t);
    int g, hi, lo, w, px;
    int grp[7];
    bus.data_valid_i  = v;
    bus.data_i        = d;
    bus.packet_type_i = t;
    @(posedge clk);
    exp_vld = 1'b0;
    exp_le  = 1'b0;
    exp_res = 1'b0;
    if (v) begin
      if (!m_prev) m_type = int'(t);
      g = gsize(m_type);
      if (g != 0) begin
        for (int i = 0; i < 4; i++) mq.push_back(d[8*i +: 8]);
        if (mq.size() >= g) begin
          for (int i = 0; i < 7; i++) begin
            grp[i] = 0;
            if (i < g) grp[i] = int'(mq[i]);
          end
          for (int i = 0; i < g; i++) void'(mq.pop_front());
          w = grp[4] | (grp[5] << 8) | (grp[6] << 16);
          for (int k = 0; k < 4; k++) begin
            case (m_type)
              3: px = grp[k] * 4 + ((grp[4] >> (2*k)) & 3);
              4: begin
                hi = (k < 2) ? grp[k] : grp[k+1];
                lo = (k < 2) ? grp[2] : grp[5];
                px = hi * 16 + (((k % 2) == 1) ? (lo >> 4) : (lo & 15));
              end
              default: px = grp[k] * 64 + ((w >> (6*k)) & 63);
            endcase
            exp_pix[k] = PB'(px);
          end
          exp_vld = 1'b1;
        end
      end
    end else if (m_prev && gsize(m_type) != 0) begin
      exp_le  = 1'b1;
      exp_res = (mq.size() != 0);
      mq.delete();
    end
    m_prev = v;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.data_valid_i = 1'b0; bus.data_i = '0; bus.packet_type_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    if ({bus.output_valid_o, bus.line_end_o, bus.residue_err_o} !== 3'b000 || bus.pixel_o !== '0) begin
      errors++;
      $display("FAIL reset: got v%b le%b re%b pix %h, want all zero",
               bus.output_valid_o, bus.line_end_o, bus.residue_err_o, bus.pixel_o);
    end
    checks++;
    rst = 1'b0;
    cyc(1'b0, '0, '0);
  endtask

  task automatic test_raw10();
    logic [31:0] d [3];
    d[0] = 32'h04030201;
    d[1] = {8'($urandom), 8'($urandom), 8'($urandom), 8'hE4};
    d[2] = $urandom;
    for (int c = 0; c < 4; c++) begin
      cyc(c < 2, (c < 3) ? d[c] : '0, 3'h3);
      if (bus.output_valid_o !== exp_vld || bus.line_end_o !== exp_le ||
          bus.residue_err_o !== exp_res || bus.pixel_o !== exp_pix) begin
        errors++;
        $display("FAIL raw10 c%0d: got v%b le%b re%b pix %h, want v%b le%b re%b pix %h", c,
                 bus.output_valid_o, bus.line_end_o, bus.residue_err_o, bus.pixel_o,
                 exp_vld, exp_le, exp_res, exp_pix);
      end
      checks++;
      if (c == 1) begin
        if (bus.pixel_o !== {16'h0013, 16'h000E, 16'h0009, 16'h0004}) begin
          errors++;
          $display("FAIL raw10_const: got %h want 0013000e00090004", bus.pixel_o);
        end
        checks++;
      end
      if (c == 2) begin
        if ({bus.line_end_o, bus.residue_err_o} !== 2'b11) begin
          errors++;
          $display("FAIL raw10_residue: got le%b re%b want le1 re1", bus.line_end_o, bus.residue_err_o);
        end
        checks++;
      end
    end
  endtask

  task automatic test_raw12();
    logic [31:0] d [2];
    d[0] = 32'h1221CDAB;
    d[1] = {8'($urandom), 8'($urandom), 8'h65, 8'h34};
    for (int c = 0; c < 3; c++) begin
      cyc(c < 2, (c < 2) ? d[c] : '0, 3'h4);
      if (bus.output_valid_o !== exp_vld || bus.line_end_o !== exp_le ||
          bus.residue_err_o !== exp_res || bus.pixel_o !== exp_pix) begin
        errors++;
        $display("FAIL raw12 c%0d: got v%b le%b re%b pix %h, want v%b le%b re%b pix %h", c,
                 bus.output_valid_o, bus.line_end_o, bus.residue_err_o, bus.pixel_o,
                 exp_vld, exp_le, exp_res, exp_pix);
      end
      checks++;
      if (c == 1) begin
        if (bus.pixel_o !== {16'h0346, 16'h0125, 16'h0CD2, 16'h0AB1}) begin
          errors++;
          $display("FAIL raw12_const: got %h want 034601250cd20ab1", bus.pixel_o);
        end
        checks++;
      end
    end
    cyc(1'b0, '0, 3'h4);
  endtask

  task automatic test_raw14();
    int beats = 0;
    logic [31:0] d;
    for (int c = 0; c < 9; c++) begin
      d = {8'(4*c+3), 8'(4*c+2), 8'(4*c+1), 8'(4*c)};
      cyc(c < 7, d, 3'h5);
      if (bus.output_valid_o === 1'b1) beats++;
      if (bus.output_valid_o !== exp_vld || bus.line_end_o !== exp_le ||
          bus.residue_err_o !== exp_res || bus.pixel_o !== exp_pix) begin
        errors++;
        $display("FAIL raw14 c%0d: got v%b le%b re%b pix %h, want v%b le%b re%b pix %h", c,
                 bus.output_valid_o, bus.line_end_o, bus.residue_err_o, bus.pixel_o,
                 exp_vld, exp_le, exp_res, exp_pix);
      end
      checks++;
    end
    if (beats != 4) begin
      errors++;
      $display("FAIL raw14_beats: got %0d want 4", beats);
    end
    checks++;
  endtask

  task automatic test_bad_type();
    for (int c = 0; c < 12; c++) begin
      cyc(c < 10, $urandom, 3'h0);
      if (bus.output_valid_o !== exp_vld || bus.line_end_o !== exp_le ||
          bus.residue_err_o !== exp_res || bus.pixel_o !== exp_pix) begin
        errors++;
        $display("FAIL bad_type c%0d: got v%b le%b re%b pix %h, want v%b le%b re%b pix %h", c,
                 bus.output_valid_o, bus.line_end_o, bus.residue_err_o, bus.pixel_o,
                 exp_vld, exp_le, exp_res, exp_pix);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, $urandom, 3'h3);
    cyc(1'b1, $urandom, 3'h3);  // 3 bytes left in the buffer
    rst = 1'b1;
    model_reset();
    #2;
    if ({bus.output_valid_o, bus.line_end_o, bus.residue_err_o} !== 3'b000 || bus.pixel_o !== '0) begin
      errors++;
      $display("FAIL reset_mid: got v%b le%b re%b pix %h, want all zero",
               bus.output_valid_o, bus.line_end_o, bus.residue_err_o, bus.pixel_o);
    end
    checks++;
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc(c < 3, $urandom, 3'h3);
      if (bus.output_valid_o !== exp_vld || bus.line_end_o !== exp_le ||
          bus.residue_err_o !== exp_res || bus.pixel_o !== exp_pix) begin
        errors++;
        $display("FAIL reset_mid c%0d: got v%b le%b re%b pix %h, want v%b le%b re%b pix %h", c,
                 bus.output_valid_o, bus.line_end_o, bus.residue_err_o, bus.pixel_o,
                 exp_vld, exp_le, exp_res, exp_pix);
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    int ends = 0;
    // RAW12 x3, idle, RAW10 x5, idle x2, then a 1-clk RAW14 burst
    logic [2:0] ty [13] = '{3'h4, 3'h4, 3'h4, 3'h3, 3'h3, 3'h3, 3'h3, 3'h3, 3'h3,
                            3'h3, 3'h3, 3'h5, 3'h5};
    logic       vl [13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                            1'b0, 1'b0, 1'b1, 1'b0};
    for (int c = 0; c < 13; c++) begin
      cyc(vl[c], $urandom, ty[c]);
      if (bus.line_end_o === 1'b1) ends++;
      if (bus.output_valid_o !== exp_vld || bus.line_end_o !== exp_le ||
          bus.residue_err_o !== exp_res || bus.pixel_o !== exp_pix) begin
        errors++;
        $display("FAIL b2b c%0d: got v%b le%b re%b pix %h, want v%b le%b re%b pix %h", c,
                 bus.output_valid_o, bus.line_end_o, bus.residue_err_o, bus.pixel_o,
                 exp_vld, exp_le, exp_res, exp_pix);
      end
      checks++;
    end
    if (ends != 3) begin
      errors++;
      $display("FAIL b2b_line_end: got %0d pulses want 3", ends);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [2:0] tl [5] = '{3'h3, 3'h4, 3'h5, 3'h0, 3'h7};
    int len, gap;
    logic [2:0] t;
    for (int b = 0; b < 40; b++) begin
      len = $urandom_range(1, 12);
      gap = $urandom_range(1, 3);
      t   = tl[$urandom_range(0, 4)];
      for (int c = 0; c < len + gap; c++) begin
        // type input wanders after the first beat; the latched type must hold
        cyc(c < len, $urandom, (c == 0) ? t : tl[$urandom_range(0, 4)]);
        if (bus.output_valid_o !== exp_vld || bus.line_end_o !== exp_le ||
            bus.residue_err_o !== exp_res || bus.pixel_o !== exp_pix) begin
          errors++;
          $display("FAIL random b%0d c%0d: got v%b le%b re%b pix %h, want v%b le%b re%b pix %h", b, c,
                   bus.output_valid_o, bus.line_end_o, bus.residue_err_o, bus.pixel_o,
                   exp_vld, exp_le, exp_res, exp_pix);
        end
        checks++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_raw10();
    test_raw12();
    test_raw14();
    test_bad_type();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
